// File: rtl/instr_decoder_pipe_pkg.sv
// instr_decoder_pipe_pkg
//   Shared definitions for the pipelined instruction decoder:
//   opcode constants, FSM state encoding and default field widths.
package instr_decoder_pipe_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_RST = 5'b00000;
  localparam logic [OP_W-1:0] OP_NOP = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST  = 5'b00010;
  localparam logic [OP_W-1:0] OP_LD  = 5'b00011;

  // Default field widths for the {opcode, reg_sel, imm} word.
  localparam int unsigned DEF_ADDR_WIDTH  = 5;
  localparam int unsigned DEF_REG_BIT_CNT = 3;
  localparam int unsigned DEF_DATA_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/instr_decoder_pipe_store_hold_counter.sv
// store_hold_counter
//   Counts the extra cycles a store strobe is held after its issue cycle.
//   Ports:
//     clk     in   clock, rising edge
//     rst     in   synchronous active-high reset
//     i_load  in   load counter with ST_CYCLES-1
//     i_dec   in   decrement counter (saturates at 0)
//     o_last  out  counter equals 1 (final hold cycle)
module store_hold_counter #(
  parameter int unsigned ST_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_last
);

  localparam int unsigned CW = $clog2(ST_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(ST_CYCLES - 1);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_last = (r_cnt == CW'(1));

endmodule

// File: rtl/instr_decoder_pipe.sv
// instr_decoder_pipe
//   Registered valid/ready instruction decoder. Splits {opcode, reg_sel, imm}
//   and issues rst_f/load/store strobes; ST holds store for ST_CYCLES cycles
//   while back-pressuring fetch.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid/in_ready/data_in  instruction input handshake
//     out_valid, opcode, reg_sel, imm  registered decoded fields
//     rst_f (active low), load, store   datapath strobes
//     busy                     store-extension in progress
//     illegal                  only with ILLEGAL_TRAP_EN: MSB-set opcode issued
//   Optional feature macro: ILLEGAL_TRAP_EN.
module instr_decoder_pipe
  import instr_decoder_pipe_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned REG_BIT_CNT = DEF_REG_BIT_CNT,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ST_CYCLES   = 2,
  localparam int unsigned COMBINED_DATA = ADDR_WIDTH + REG_BIT_CNT + DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COMBINED_DATA-1:0] data_in,
  output logic                     out_valid,
  output logic [ADDR_WIDTH-1:0]    opcode,
  output logic [REG_BIT_CNT-1:0]   reg_sel,
  output logic [DATA_WIDTH-1:0]    imm,
  output logic                     rst_f,
  output logic                     load,
  output logic                     store,
  output logic                     busy
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                     illegal
`endif
);

  localparam int unsigned OPC_LSB = REG_BIT_CNT + DATA_WIDTH;
  localparam int unsigned REG_LSB = DATA_WIDTH;

  if (ST_CYCLES < 1) begin : g_bad_st_cycles
    $error("ST_CYCLES must be >= 1");
  end

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_WIDTH-1:0]  r_opcode;
  logic [REG_BIT_CNT-1:0] r_reg_sel;
  logic [DATA_WIDTH-1:0]  r_imm;

  logic w_accept;
  logic w_illegal_op;
  logic w_st_hold;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_last;
  logic w_illegal;

`ifdef ILLEGAL_TRAP_EN
  assign w_illegal_op = r_opcode[ADDR_WIDTH-1];
  assign illegal      = w_illegal;
`else
  assign w_illegal_op = 1'b0;
`endif

  // An issuing ST that will extend into HOLD cannot accept on its issue edge,
  // so ready drops already in the ISSUE cycle, not only in HOLD.
  assign w_st_hold = (r_opcode == ADDR_WIDTH'(OP_ST)) && !w_illegal_op &&
                     (ST_CYCLES > 1);
  assign in_ready  = !rst && (r_state != HOLD) &&
                     !((r_state == ISSUE) && w_st_hold);
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode  <= '0;
      r_reg_sel <= '0;
      r_imm     <= '0;
    end else if (w_accept) begin
      r_opcode  <= data_in[COMBINED_DATA-1 -: ADDR_WIDTH];
      r_reg_sel <= data_in[OPC_LSB-1 -: REG_BIT_CNT];
      r_imm     <= data_in[REG_LSB-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = ISSUE;
      end
      ISSUE: begin
        if (w_st_hold) begin
          w_next     = HOLD;
          w_cnt_load = 1'b1;
        end else if (w_accept) begin
          w_next = ISSUE;
        end else begin
          w_next = IDLE;
        end
      end
      HOLD: begin
        if (w_cnt_last) w_next = IDLE;
        else            w_cnt_dec = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    rst_f     = 1'b1;
    load      = 1'b0;
    store     = 1'b0;
    w_illegal = 1'b0;
    out_valid = (r_state != IDLE);
    busy      = (r_state == HOLD);
    if (r_state == ISSUE) begin
      if (w_illegal_op) begin
        w_illegal = 1'b1;
      end else begin
        case (r_opcode)
          ADDR_WIDTH'(OP_RST): rst_f = 1'b0;
          ADDR_WIDTH'(OP_NOP): ;
          ADDR_WIDTH'(OP_ST):  store = 1'b1;
          default:             load  = 1'b1;
        endcase
      end
    end else if (r_state == HOLD) begin
      store = 1'b1;
    end
  end

  assign opcode  = r_opcode;
  assign reg_sel = r_reg_sel;
  assign imm     = r_imm;

  store_hold_counter #(
    .ST_CYCLES(ST_CYCLES)
  ) u_store_hold_counter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_cnt_load),
    .i_dec  (w_cnt_dec),
    .o_last (w_cnt_last)
  );

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// tb_instr_decoder_pipe
//   Directed bench for instr_decoder_pipe. u_dut uses ST_CYCLES=2, u_dut1 uses
//   ST_CYCLES=1; both share the input stimulus.
module tb_instr_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [23:0] data_in;

  logic        in_ready, out_valid, rst_f, load, store, busy;
  logic [4:0]  opcode;
  logic [2:0]  reg_sel;
  logic [15:0] imm;

  logic        in_ready1, out_valid1, rst_f1, load1, store1, busy1;
  logic [4:0]  opcode1;
  logic [2:0]  reg_sel1;
  logic [15:0] imm1;

`ifdef ILLEGAL_TRAP_EN
  logic        illegal, illegal1;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  instr_decoder_pipe #(.ST_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .opcode(opcode),
    .reg_sel(reg_sel), .imm(imm), .rst_f(rst_f), .load(load),
    .store(store), .busy(busy)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  instr_decoder_pipe #(.ST_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .data_in(data_in), .out_valid(out_valid1), .opcode(opcode1),
    .reg_sel(reg_sel1), .imm(imm1), .rst_f(rst_f1), .load(load1),
    .store(store1), .busy(busy1)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal1)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] mk(input logic [4:0] op, input logic [2:0] rs,
                                     input logic [15:0] im);
    return {op, rs, im};
  endfunction

  initial begin
    // Reset with in_valid high: nothing must be accepted.
    rst      = 1'b1;
    in_valid = 1'b1;
    data_in  = mk(5'b00011, 3'd5, 16'hBEEF);
    #1;
    check_eq("rst_in_ready_comb", in_ready, 0);
    step();
    step();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_rst_f", rst_f, 1);
    check_eq("rst_load", load, 0);
    check_eq("rst_store", store, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_imm", imm, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check_eq("post_rst_out_valid", out_valid, 0);
    check_eq("post_rst_opcode", opcode, 0);

    // Single LD
    in_valid = 1'b1;
    data_in  = mk(5'b00011, 3'd5, 16'hBEEF);
    check_eq("ld_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_eq("ld_out_valid", out_valid, 1);
    check_eq("ld_load", load, 1);
    check_eq("ld_store", store, 0);
    check_eq("ld_rst_f", rst_f, 1);
    check_eq("ld_opcode", opcode, 5'b00011);
    check_eq("ld_reg_sel", reg_sel, 5);
    check_eq("ld_imm", imm, 16'hBEEF);
    step();
    check_eq("ld_after_load", load, 0);
    check_eq("ld_after_valid", out_valid, 0);
    check_eq("ld_after_imm_hold", imm, 16'hBEEF);

    // Back-to-back LD, NOP, RST
    in_valid = 1'b1;
    data_in  = mk(5'b00011, 3'd1, 16'h1111);
    step();
    check_eq("b2b_ld_load", load, 1);
    check_eq("b2b_ld_ready", in_ready, 1);
    data_in = mk(5'b00001, 3'd2, 16'h2222);
    step();
    check_eq("b2b_nop_valid", out_valid, 1);
    check_eq("b2b_nop_opcode", opcode, 5'b00001);
    check_eq("b2b_nop_load", load, 0);
    check_eq("b2b_nop_store", store, 0);
    check_eq("b2b_nop_rst_f", rst_f, 1);
    check_eq("b2b_nop_ready", in_ready, 1);
    data_in = mk(5'b00000, 3'd3, 16'h3333);
    step();
    in_valid = 1'b0;
    check_eq("b2b_rst_valid", out_valid, 1);
    check_eq("b2b_rst_rst_f", rst_f, 0);
    check_eq("b2b_rst_load", load, 0);
    check_eq("b2b_rst_ready", in_ready, 1);
    check_eq("b2b_rst_imm", imm, 16'h3333);
    step();
    check_eq("b2b_end_rst_f", rst_f, 1);
    check_eq("b2b_end_valid", out_valid, 0);

    // ST hold (ST_CYCLES=2) with a waiting LD behind it
    in_valid = 1'b1;
    data_in  = mk(5'b00010, 3'd3, 16'h00AA);
    step();                                   // edge N
    data_in = mk(5'b00011, 3'd2, 16'h4444);
    check_eq("st_n1_store", store, 1);
    check_eq("st_n1_ready", in_ready, 0);
    check_eq("st_n1_busy", busy, 0);
    check_eq("st_n1_reg_sel", reg_sel, 3);
    check_eq("st_n1_load", load, 0);
    check_eq("st1_n1_store", store1, 1);
    check_eq("st1_n1_ready", in_ready1, 1);
    check_eq("st1_n1_busy", busy1, 0);
    step();                                   // edge N+1
    check_eq("st_n2_store", store, 1);
    check_eq("st_n2_ready", in_ready, 0);
    check_eq("st_n2_busy", busy, 1);
    check_eq("st_n2_valid", out_valid, 1);
    check_eq("st_n2_opcode", opcode, 5'b00010);
    check_eq("st_n2_imm", imm, 16'h00AA);
    check_eq("st1_n2_store", store1, 0);
    check_eq("st1_n2_load", load1, 1);
    check_eq("st1_n2_opcode", opcode1, 5'b00011);
    step();                                   // edge N+2
    check_eq("st_n3_store", store, 0);
    check_eq("st_n3_busy", busy, 0);
    check_eq("st_n3_valid", out_valid, 0);
    check_eq("st_n3_ready", in_ready, 1);
    check_eq("st_n3_opcode_frozen", opcode, 5'b00010);
    step();                                   // edge N+3: LD accepted
    in_valid = 1'b0;
    check_eq("st_n4_load", load, 1);
    check_eq("st_n4_reg_sel", reg_sel, 2);
    step();
    check_eq("st_n5_valid", out_valid, 0);

    // Reset during the HOLD cycle
    in_valid = 1'b1;
    data_in  = mk(5'b00010, 3'd6, 16'h5555);
    step();
    in_valid = 1'b0;
    step();
    check_eq("rhold_store_before", store, 1);
    check_eq("rhold_busy_before", busy, 1);
    rst = 1'b1;
    step();
    check_eq("rhold_store", store, 0);
    check_eq("rhold_busy", busy, 0);
    check_eq("rhold_valid", out_valid, 0);
    rst = 1'b0;
    step();
    check_eq("rhold_residual_store", store, 0);
    check_eq("rhold_ready", in_ready, 1);

    // Upper-half opcode
    in_valid = 1'b1;
    data_in  = mk(5'b10101, 3'd0, 16'h0000);
    step();
    in_valid = 1'b0;
    check_eq("ill_valid", out_valid, 1);
    check_eq("ill_store", store, 0);
    check_eq("ill_rst_f", rst_f, 1);
`ifdef ILLEGAL_TRAP_EN
    check_eq("ill_illegal", illegal, 1);
    check_eq("ill_load", load, 0);
`else
    check_eq("ill_load_default", load, 1);
`endif
    step();
    check_eq("ill_after_load", load, 0);
`ifdef ILLEGAL_TRAP_EN
    check_eq("ill_after_illegal", illegal, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
